// File: rtl/jk_load_counter.sv
// Loadable up-counter with JK toggle-chain semantics, stepped by rising edges of
// a logical clock CLK that is sampled on MasterClock.
module jk_load_counter #(
  parameter int WIDTH = 9
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  input  logic             CLK,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic             RELOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             CO,
  output logic             TCP
);

  logic             clk_d;
  logic             clk_rise;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tog;
  logic             tcp;
  logic             term;

  assign clk_rise = CLK & ~clk_d;
  assign term     = &q;

  // Toggle enables of the JK chain: stage i flips when EN and all lower stages are 1
  always_comb begin
    tog    = '0;
    tog[0] = EN;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      tog[i] = tog[i-1] & q[i-1];
    end
  end

  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      clk_d <= 1'b1;
      q     <= '0;
      tcp   <= 1'b0;
    end else begin
      clk_d <= CLK;
      tcp   <= 1'b0;
      if (clk_rise) begin
        if (CLR) begin
          q <= '0;
        end else if (LD) begin
          q <= D;
        end else if (EN && term) begin
          q   <= RELOAD ? D : '0;
          tcp <= 1'b1;
        end else begin
          q <= q ^ tog;
        end
      end
    end
  end

  assign Q   = q;
  assign QB  = ~q;
  assign TCP = tcp;
  assign CO  = EN & ~CLR & ~LD & term;

endmodule

// File: tb/tb_jk_load_counter.sv
// Directed bench for jk_load_counter (WIDTH=9) with hand-computed expectations.
module tb_jk_load_counter;

  localparam int W = 9;

  logic         MasterClock = 1'b0;
  logic         RESETL;
  logic         CLK;
  logic         EN;
  logic         CLR;
  logic         LD;
  logic         RELOAD;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic [W-1:0] QB;
  logic         CO;
  logic         TCP;

  int checks   = 0;
  int failures = 0;

  jk_load_counter #(.WIDTH(W)) dut (
    .MasterClock(MasterClock),
    .RESETL     (RESETL),
    .CLK        (CLK),
    .EN         (EN),
    .CLR        (CLR),
    .LD         (LD),
    .RELOAD     (RELOAD),
    .D          (D),
    .Q          (Q),
    .QB         (QB),
    .CO         (CO),
    .TCP        (TCP)
  );

  always #5 MasterClock = ~MasterClock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic clk_rise();
    @(negedge MasterClock);
    CLK = 1'b1;
    @(posedge MasterClock);
    #1;
  endtask

  task automatic clk_fall();
    @(negedge MasterClock);
    CLK = 1'b0;
    @(posedge MasterClock);
    #1;
  endtask

  task automatic clk_pulse();
    clk_rise();
    clk_fall();
  endtask

  task automatic load_value(input logic [W-1:0] v);
    CLR = 1'b0; LD = 1'b1; D = v;
    clk_pulse();
    LD = 1'b0;
  endtask

  task automatic test_reset();
    RESETL = 1'b0; CLK = 1'b1; EN = 1'b1; CLR = 1'b0; LD = 1'b0;
    RELOAD = 1'b0; D = 9'h1FF;
    #2;
    checks++; if (Q !== 9'h000) begin failures++; $display("FAIL reset_q: got %h want %h", Q, 9'h000); end
    checks++; if (QB !== 9'h1FF) begin failures++; $display("FAIL reset_qb: got %h want %h", QB, 9'h1FF); end
    checks++; if (CO !== 1'b0) begin failures++; $display("FAIL reset_co: got %b want 0", CO); end
    checks++; if (TCP !== 1'b0) begin failures++; $display("FAIL reset_tcp: got %b want 0", TCP); end
    @(posedge MasterClock);
    @(negedge MasterClock);
    RESETL = 1'b1;
    repeat (3) @(posedge MasterClock);
    #1;
    checks++; if (Q !== 9'h000) begin failures++; $display("FAIL release_high_no_count: got %h want %h", Q, 9'h000); end
    clk_fall();
  endtask

  task automatic test_count();
    EN = 1'b1;
    @(negedge MasterClock);
    CLK = 1'b1;
    #1;
    checks++; if (Q !== 9'h000) begin failures++; $display("FAIL count_before_edge: got %h want %h", Q, 9'h000); end
    @(posedge MasterClock);
    #1;
    checks++; if (Q !== 9'h001) begin failures++; $display("FAIL count_on_edge: got %h want %h", Q, 9'h001); end
    clk_fall();
    repeat (4) clk_pulse();
    checks++; if (Q !== 9'h005) begin failures++; $display("FAIL count_five: got %h want %h", Q, 9'h005); end
    checks++; if (QB !== 9'h1FA) begin failures++; $display("FAIL count_five_qb: got %h want %h", QB, 9'h1FA); end
  endtask

  task automatic test_edge_only();
    EN = 1'b1;
    @(negedge MasterClock);
    CLK = 1'b1;
    repeat (10) @(posedge MasterClock);
    #1;
    checks++; if (Q !== 9'h006) begin failures++; $display("FAIL held_high_single_step: got %h want %h", Q, 9'h006); end
    clk_fall();
    checks++; if (Q !== 9'h006) begin failures++; $display("FAIL fall_no_step: got %h want %h", Q, 9'h006); end
  endtask

  task automatic test_terminal();
    RELOAD = 1'b0;
    load_value(9'h1FE);
    EN = 1'b1;
    checks++; if (CO !== 1'b0) begin failures++; $display("FAIL co_at_1fe: got %b want 0", CO); end
    clk_pulse();
    checks++; if (Q !== 9'h1FF) begin failures++; $display("FAIL term_reach: got %h want %h", Q, 9'h1FF); end
    checks++; if (CO !== 1'b1) begin failures++; $display("FAIL co_at_1ff: got %b want 1", CO); end
    checks++; if (TCP !== 1'b0) begin failures++; $display("FAIL tcp_before_wrap: got %b want 0", TCP); end
    EN = 1'b0;
    #1;
    checks++; if (CO !== 1'b0) begin failures++; $display("FAIL co_en_low: got %b want 0", CO); end
    EN = 1'b1;
    clk_rise();
    checks++; if (Q !== 9'h000) begin failures++; $display("FAIL wrap_q: got %h want %h", Q, 9'h000); end
    checks++; if (TCP !== 1'b1) begin failures++; $display("FAIL wrap_tcp_high: got %b want 1", TCP); end
    checks++; if (CO !== 1'b0) begin failures++; $display("FAIL co_after_wrap: got %b want 0", CO); end
    @(posedge MasterClock);
    #1;
    checks++; if (TCP !== 1'b0) begin failures++; $display("FAIL wrap_tcp_one_cycle: got %b want 0", TCP); end
    clk_fall();
  endtask

  task automatic test_reload();
    load_value(9'h1FF);
    RELOAD = 1'b1; D = 9'h150; EN = 1'b1;
    clk_rise();
    checks++; if (Q !== 9'h150) begin failures++; $display("FAIL reload_q: got %h want %h", Q, 9'h150); end
    checks++; if (TCP !== 1'b1) begin failures++; $display("FAIL reload_tcp: got %b want 1", TCP); end
    clk_fall();
    load_value(9'h1FF);
    RELOAD = 1'b0; D = 9'h150;
    clk_rise();
    checks++; if (Q !== 9'h000) begin failures++; $display("FAIL noreload_q: got %h want %h", Q, 9'h000); end
    checks++; if (TCP !== 1'b1) begin failures++; $display("FAIL noreload_tcp: got %b want 1", TCP); end
    clk_fall();
  endtask

  task automatic test_priority();
    RELOAD = 1'b1;
    load_value(9'h1FF);
    CLR = 1'b1; LD = 1'b1; EN = 1'b1; D = 9'h0AA;
    #1;
    checks++; if (CO !== 1'b0) begin failures++; $display("FAIL co_masked_by_clr: got %b want 0", CO); end
    clk_rise();
    checks++; if (Q !== 9'h000) begin failures++; $display("FAIL clr_priority_q: got %h want %h", Q, 9'h000); end
    checks++; if (TCP !== 1'b0) begin failures++; $display("FAIL clr_masks_tcp: got %b want 0", TCP); end
    clk_fall();
    CLR = 1'b0;
    load_value(9'h1FF);
    LD = 1'b1; EN = 1'b1; D = 9'h0AA;
    clk_rise();
    checks++; if (Q !== 9'h0AA) begin failures++; $display("FAIL ld_priority_q: got %h want %h", Q, 9'h0AA); end
    checks++; if (TCP !== 1'b0) begin failures++; $display("FAIL ld_masks_tcp: got %b want 0", TCP); end
    clk_fall();
    CLR = 1'b1; D = 9'h055;
    repeat (3) @(posedge MasterClock);
    #1;
    checks++; if (Q !== 9'h0AA) begin failures++; $display("FAIL hold_without_edge: got %h want %h", Q, 9'h0AA); end
    CLR = 1'b0; LD = 1'b0; RELOAD = 1'b0;
  endtask

  task automatic test_async_reset();
    load_value(9'h123);
    EN = 1'b1;
    checks++; if (Q !== 9'h123) begin failures++; $display("FAIL load_123: got %h want %h", Q, 9'h123); end
    @(posedge MasterClock);
    #2;
    RESETL = 1'b0;
    #1;
    checks++; if (Q !== 9'h000) begin failures++; $display("FAIL async_reset_q: got %h want %h", Q, 9'h000); end
    checks++; if (QB !== 9'h1FF) begin failures++; $display("FAIL async_reset_qb: got %h want %h", QB, 9'h1FF); end
    @(negedge MasterClock);
    RESETL = 1'b1;
    @(posedge MasterClock);
    #1;
    clk_pulse();
    checks++; if (Q !== 9'h001) begin failures++; $display("FAIL after_reset_count: got %h want %h", Q, 9'h001); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_edge_only();
    test_terminal();
    test_reload();
    test_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
